// File: rtl/test_harness_ctrl_if.sv
// Bundle between the bench/board side (master) and the run controller (slave):
// start request, per-channel CPU status in, reset and verdict out.
interface test_harness_ctrl_if #(
    parameter int NUM_CH = 1,
    parameter int CNT_W  = 32
);
    logic              start;
    logic [NUM_CH-1:0] terminal;
    logic [NUM_CH-1:0] correct;
    logic              dut_rstn;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [NUM_CH-1:0] fail_mask;
    logic [CNT_W-1:0]  cycles;
    logic [7:0]        run_idx;

    modport master (
        output start, terminal, correct,
        input  dut_rstn, busy, done, pass, timeout, fail_mask, cycles, run_idx
    );

    modport slave (
        input  start, terminal, correct,
        output dut_rstn, busy, done, pass, timeout, fail_mask, cycles, run_idx
    );
endinterface

// File: rtl/test_harness_ctrl.sv
// Run controller for CPU self-check builds: sequences DUT reset, watches
// terminal/correct per channel under a watchdog, repeats runs, latches verdict.
module test_harness_ctrl #(
    parameter int          NUM_CH         = 1,
    parameter int          RESET_CYCLES   = 4,
    parameter int          CNT_W          = 32,
    parameter longint      TIMEOUT_CYCLES = 100000,
    parameter int          NUM_RUNS       = 1,
    parameter bit          STOP_ON_FAIL   = 1'b1
) (
    input logic               clk,
    input logic               rst,
    test_harness_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RESET = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int               RCNT_W   = $clog2(RESET_CYCLES + 1);
    localparam logic [RCNT_W-1:0] RST_LAST = RCNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]        RUNS     = 8'(NUM_RUNS);

    logic [2:0]        r_state;
    logic [RCNT_W-1:0] r_rcnt;
    logic [CNT_W-1:0]  r_cnt;
    logic [NUM_CH-1:0] r_fin;
    logic [NUM_CH-1:0] r_ok;
    logic              r_dut_rstn;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              r_timeout;
    logic [NUM_CH-1:0] r_fail_mask;
    logic [CNT_W-1:0]  r_cycles;
    logic [7:0]        r_run_idx;

    logic [NUM_CH-1:0] w_new;
    logic [NUM_CH-1:0] w_fin_nxt;
    logic [NUM_CH-1:0] w_ok_nxt;
    logic              w_all_fin;
    logic              w_wd;
    logic [NUM_CH-1:0] w_run_fail_vec;
    logic              w_run_fail;
    logic [NUM_CH-1:0] w_mask_nxt;
    logic              w_last;

    // Only the first terminal pulse of a channel counts; later values are dropped.
    assign w_new          = bus.terminal & ~r_fin;
    assign w_fin_nxt      = r_fin | bus.terminal;
    assign w_ok_nxt       = (r_ok & ~w_new) | (w_new & bus.correct);
    assign w_all_fin      = &w_fin_nxt;
    assign w_wd           = (r_cnt == WD_LAST);
    assign w_run_fail_vec = ~(r_fin & r_ok);
    assign w_run_fail     = |w_run_fail_vec;
    assign w_mask_nxt     = r_fail_mask | w_run_fail_vec;
    assign w_last         = ((r_run_idx + 8'd1) == RUNS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rcnt      <= '0;
            r_cnt       <= '0;
            r_fin       <= '0;
            r_ok        <= '0;
            r_dut_rstn  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_fail_mask <= '0;
            r_cycles    <= '0;
            r_run_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state     <= S_RESET;
                        r_rcnt      <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_fail_mask <= '0;
                        r_cycles    <= '0;
                        r_run_idx   <= '0;
                    end
                end
                S_RESET: begin
                    r_cnt <= '0;
                    r_fin <= '0;
                    r_ok  <= '0;
                    if (r_rcnt == RST_LAST) begin
                        r_state    <= S_RUN;
                        r_dut_rstn <= 1'b1;
                    end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
                S_RUN: begin
                    r_fin <= w_fin_nxt;
                    r_ok  <= w_ok_nxt;
                    // Completion takes priority over a same-cycle watchdog expiry.
                    if (w_all_fin) begin
                        r_state    <= S_CHECK;
                        r_dut_rstn <= 1'b0;
                    end else if (w_wd) begin
                        r_state    <= S_CHECK;
                        r_dut_rstn <= 1'b0;
                        r_timeout  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    r_fail_mask <= w_mask_nxt;
                    r_cycles    <= r_cnt;
                    r_run_idx   <= r_run_idx + 8'd1;
                    if (w_last || (STOP_ON_FAIL && w_run_fail)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_mask_nxt == '0) && !r_timeout;
                    end else begin
                        r_state <= S_RESET;
                        r_rcnt  <= '0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_dut_rstn <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dut_rstn  = r_dut_rstn;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.timeout   = r_timeout;
    assign bus.fail_mask = r_fail_mask;
    assign bus.cycles    = r_cycles;
    assign bus.run_idx   = r_run_idx;
endmodule

// File: tb/tb_test_harness_ctrl.sv
// Randomized bench for test_harness_ctrl: per-run channel schedules drive the
// DUT, a run-level model predicts the waveform and verdict, one process compares.
module tb_test_harness_ctrl;
    localparam int NCH   = 4;
    localparam int RC    = 4;
    localparam int CW    = 32;
    localparam int TO    = 100;
    localparam int NR    = 3;
    localparam bit SOF   = 1'b1;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    test_harness_ctrl_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    test_harness_ctrl #(
        .NUM_CH(NCH), .RESET_CYCLES(RC), .CNT_W(CW),
        .TIMEOUT_CYCLES(TO), .NUM_RUNS(NR), .STOP_ON_FAIL(SOF)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        bit           rstn, busy, done, res;
        bit           pass, tmo;
        bit [NCH-1:0] mask;
        int           cyc, ridx;
    } exp_t;

    exp_t exp_q[$];
    int   t_tab[NR][NCH];
    bit   c_tab[NR][NCH];
    int   errors = 0, checks = 0;

    bit [NCH-1:0] m_mask;
    bit           m_tmo, m_pass;
    int           m_cyc, m_ridx;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_n(int n, bit rstn, bit busy);
        exp_t e;
        e = '{rstn: rstn, busy: busy, done: 1'b0, res: 1'b0, pass: 1'b0,
              tmo: 1'b0, mask: '0, cyc: 0, ridx: 0};
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // Run-level model: each run ends at the latest terminal if all channels
    // report by TO-1, otherwise at TO-1 with a timeout.
    task automatic build_expect();
        exp_t e;
        m_mask = '0; m_tmo = 1'b0; m_cyc = 0; m_ridx = 0;
        for (int r = 0; r < NR; r++) begin
            int           last = 0;
            bit           all = 1'b1;
            bit [NCH-1:0] fv = '0;
            int           n_end;
            for (int ch = 0; ch < NCH; ch++) begin
                if (t_tab[r][ch] <= TO - 1) begin
                    if (t_tab[r][ch] > last) last = t_tab[r][ch];
                    if (!c_tab[r][ch]) fv[ch] = 1'b1;
                end else begin
                    all = 1'b0;
                    fv[ch] = 1'b1;
                end
            end
            n_end = all ? last : TO - 1;
            if (!all) m_tmo = 1'b1;
            push_n(RC, 1'b0, 1'b1);
            push_n(n_end + 1, 1'b1, 1'b1);
            push_n(1, 1'b0, 1'b1);
            m_mask |= fv;
            m_cyc  = n_end;
            m_ridx = r + 1;
            if (SOF && fv != '0) break;
        end
        m_pass = (m_mask == '0) && !m_tmo;
        e = '{rstn: 1'b0, busy: 1'b0, done: 1'b1, res: 1'b1, pass: m_pass,
              tmo: m_tmo, mask: m_mask, cyc: m_cyc, ridx: m_ridx};
        for (int i = 0; i < 3; i++) exp_q.push_back(e);
    endtask

    always @(negedge clk) begin : cmp
        exp_t e;
        if (exp_q.size() > 0 && !rst) begin
            e = exp_q.pop_front();
            chk("dut_rstn", bus.dut_rstn, e.rstn);
            chk("busy", bus.busy, e.busy);
            chk("done", bus.done, e.done);
            if (e.res) begin
                chk("pass", bus.pass, e.pass);
                chk("timeout", bus.timeout, e.tmo);
                chk("fail_mask", bus.fail_mask, e.mask);
                chk("cycles", bus.cycles, e.cyc);
                chk("run_idx", bus.run_idx, e.ridx);
            end
        end
    end

    // Channel model: counts cycles since dut_rstn rose, pulses terminal at its
    // scheduled cycle, and drives noise whenever the result must be ignored.
    int run_no = 0, k = 0;
    bit prev_rstn = 1'b0;
    always @(negedge clk) begin : drv
        logic [NCH-1:0] tv, cv;
        int             ri;
        tv = NCH'($urandom);
        cv = NCH'($urandom);
        if (!bus.busy) run_no = 0;
        if (bus.dut_rstn) begin
            if (!prev_rstn) begin
                run_no++;
                k = 0;
            end else begin
                k++;
            end
            ri = (run_no >= 1 && run_no <= NR) ? run_no - 1 : 0;
            for (int ch = 0; ch < NCH; ch++) begin
                if (k < t_tab[ri][ch]) tv[ch] = 1'b0;
                else if (k == t_tab[ri][ch]) begin
                    tv[ch] = 1'b1;
                    cv[ch] = c_tab[ri][ch];
                end
            end
        end
        bus.terminal = tv;
        bus.correct  = cv;
        prev_rstn    = bus.dut_rstn;
    end

    task automatic setrun(int r, int t0, int t1, int t2, int t3, bit [3:0] cvec);
        t_tab[r] = '{t0, t1, t2, t3};
        for (int ch = 0; ch < NCH; ch++) c_tab[r][ch] = cvec[ch];
    endtask

    task automatic chk_zero(string p);
        chk({p, "_rstn"}, bus.dut_rstn, 0);
        chk({p, "_busy"}, bus.busy, 0);
        chk({p, "_done"}, bus.done, 0);
        chk({p, "_pass"}, bus.pass, 0);
        chk({p, "_timeout"}, bus.timeout, 0);
        chk({p, "_mask"}, bus.fail_mask, 0);
        chk({p, "_cycles"}, bus.cycles, 0);
        chk({p, "_run_idx"}, bus.run_idx, 0);
    endtask

    task automatic run_seq();
        int guard = 0;
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        build_expect();
        @(negedge clk) bus.start = 1'b0;
        // A start pulse while the sequence is busy must be ignored.
        repeat ($urandom_range(1, 3)) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        while (exp_q.size() > 0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("seq_complete", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        for (int r = 0; r < NR; r++) setrun(r, 1, 1, 1, 1, 4'b1111);
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // A: every run passes, last terminal at cycle 50.
        for (int r = 0; r < NR; r++) setrun(r, 10, 20, 30, 50, 4'b1111);
        run_seq();
        chk("pinA_model_cyc", m_cyc, 50);
        chk("pinA_cycles", bus.cycles, 50);
        chk("pinA_pass", bus.pass, 1);
        chk("pinA_run_idx", bus.run_idx, 3);

        // B: run 2 has channel 1 incorrect; stop-on-fail ends after run 2.
        setrun(0, 5, 5, 5, 5, 4'b1111);
        setrun(1, 10, 20, 30, 40, 4'b1101);
        setrun(2, 7, 7, 7, 7, 4'b1111);
        run_seq();
        chk("pinB_model_mask", m_mask, 4'b0010);
        chk("pinB_mask", bus.fail_mask, 4'b0010);
        chk("pinB_run_idx", bus.run_idx, 2);
        chk("pinB_cycles", bus.cycles, 40);
        chk("pinB_pass", bus.pass, 0);

        // C: channel 1 never terminates -> watchdog at counter 99.
        setrun(0, 3, NEVER, 7, 8, 4'b1111);
        run_seq();
        chk("pinC_model_tmo", m_tmo, 1);
        chk("pinC_timeout", bus.timeout, 1);
        chk("pinC_mask", bus.fail_mask, 4'b0010);
        chk("pinC_cycles", bus.cycles, 99);
        chk("pinC_run_idx", bus.run_idx, 1);

        // D: last channel terminates on the watchdog cycle; restart clears mask.
        for (int r = 0; r < NR; r++) setrun(r, 10, 10, 10, 99, 4'b1111);
        run_seq();
        chk("pinD_timeout", bus.timeout, 0);
        chk("pinD_mask", bus.fail_mask, 0);
        chk("pinD_pass", bus.pass, 1);
        chk("pinD_cycles", bus.cycles, 99);

        for (int s = 0; s < 12; s++) begin
            for (int r = 0; r < NR; r++)
                for (int ch = 0; ch < NCH; ch++) begin
                    t_tab[r][ch] = ($urandom_range(0, 9) == 0) ? NEVER
                                                               : int'($urandom_range(0, 120));
                    c_tab[r][ch] = ($urandom_range(0, 5) != 0);
                end
            run_seq();
        end

        // Async reset in the middle of a run.
        for (int r = 0; r < NR; r++) setrun(r, 10, 20, 30, 50, 4'b1111);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (RC + 5) @(posedge clk);
        chk("pre_rst_rstn", bus.dut_rstn, 1);
        #2 rst = 1'b1;
        #1 chk_zero("async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("post_rst");

        run_seq();
        chk("final_pass", bus.pass, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
